alu_muldiv_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_muldiv_sequencer_if.sv | 26 ++
 rtl/alu_muldiv_sequencer_muldiv_step.sv | 46 ++++
 rtl/alu_muldiv_sequencer.sv | 111 +++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the multiply/divide sequencer.
// Holds the ALU opcodes used by the sequencer, the mul/div op select and FSM state encoding.
// No ports; imported with "import alu_pkg::*".
package alu_pkg;

  // ALU opcodes, matching the alu_bit_slice decode
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;

  // Sequencer operation select
  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Start/done handshake between pipeline control and the multiply/divide sequencer.
// master: pipeline control (drives start/op/a/b, reads status and results).
// slave:  sequencer (reads request, drives busy/done/results/div_by_zero).
interface alu_muldiv_sequencer_if #(
  parameter int N = 32
);
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result_hi;
  logic [N-1:0] result_lo;
  logic         div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_sequencer_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide: next HI/LO from the ALU result.
// Ports: op (0 mul / 1 div), hi, lo, alu_f, alu_cout in; hi_nxt, lo_nxt out.
// Purely combinational; the sequencer registers the outputs once per RUN cycle.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         op,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] alu_f,
  input  logic         alu_cout,
  output logic [N-1:0] hi_nxt,
  output logic [N-1:0] lo_nxt
);

  // Partial remainder shifted left with the next dividend bit
  logic [N-1:0] s;
  assign s = {hi[N-2:0], lo[N-1]};

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (op == MD_OP_DIV) begin
      // hi[N-1] is the bit shifted out of s: the true shifted remainder is
      // then >= 2^N > divisor, so subtract regardless of borrow. The mod-2^N
      // difference is exact because the real difference is below the divisor.
      if (hi[N-1] | alu_cout) begin
        hi_nxt = alu_f;
        lo_nxt = {lo[N-2:0], 1'b1};
      end else begin
        hi_nxt = s;
        lo_nxt = {lo[N-2:0], 1'b0};
      end
    end else begin
      // Carry-out of the add becomes the new top bit of the product
      if (lo[0]) begin
        {hi_nxt, lo_nxt} = {alu_cout, alu_f, lo[N-1:1]};
      end else begin
        {hi_nxt, lo_nxt} = {1'b0, hi, lo[N-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned NxN multiply / NxN divide using the shared combinational ALU.
// Ports: clk, rst (async, active-high); md (handshake/results, slave side);
// alu_c/alu_cin/alu_a/alu_b drive the ALU, alu_f/alu_cout read it back the same cycle.
module alu_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_muldiv_sequencer_if.slave md,
  output logic [2:0]            alu_c,
  output logic                  alu_cin,
  output logic [N-1:0]          alu_a,
  output logic [N-1:0]          alu_b,
  input  logic [N-1:0]          alu_f,
  input  logic                  alu_cout
);

  localparam int CW = $clog2(N);

  md_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] hi, lo, opr;
  logic         op_q;
  logic         dbz;
  logic [N-1:0] hi_nxt, lo_nxt;
  logic         accept;
  logic         req_dbz;

  assign accept  = (state == ST_IDLE) && md.start;
  assign req_dbz = (md.op == MD_OP_DIV) && (md.b == '0);

  muldiv_step #(.N(N)) u_step (
    .op       (op_q),
    .hi       (hi),
    .lo       (lo),
    .alu_f    (alu_f),
    .alu_cout (alu_cout),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and ALU drive; outside RUN the ALU sees a harmless 0+0
  always_comb begin
    state_nxt = state;
    alu_c     = ALU_OP_ADD;
    alu_cin   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      ST_IDLE: begin
        if (md.start) state_nxt = req_dbz ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        alu_b = opr;
        if (op_q == MD_OP_DIV) begin
          alu_c   = ALU_OP_SUB;
          alu_cin = 1'b1;
          alu_a   = {hi[N-2:0], lo[N-1]};
        end else begin
          alu_a   = hi;
        end
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      opr  <= '0;
      op_q <= MD_OP_MUL;
      dbz  <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      op_q <= md.op;
      dbz  <= req_dbz;
      cnt  <= CW'(N - 1);
      if (md.op == MD_OP_DIV) begin
        // Divide by zero skips RUN and reports quotient all-ones, remainder = dividend
        hi  <= req_dbz ? md.a : '0;
        lo  <= req_dbz ? '1 : md.a;
        opr <= md.b;
      end else begin
        hi  <= '0;
        lo  <= md.b;
        opr <= md.a;
      end
    end else if (state == ST_RUN) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign md.busy        = (state != ST_IDLE);
  assign md.done        = (state == ST_DONE);
  assign md.result_hi   = hi;
  assign md.result_lo   = lo;
  assign md.div_by_zero = dbz;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
module tb_alu_muldiv_sequencer;
  import alu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_sequencer_if #(.N(N)) md();

  logic [2:0]   alu_c;
  logic         alu_cin;
  logic [N-1:0] alu_a, alu_b, alu_f;
  logic         alu_cout;

  alu_muldiv_sequencer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .md       (md),
    .alu_c    (alu_c),
    .alu_cin  (alu_cin),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .alu_cout (alu_cout)
  );

  // Behavioural stand-in for the shared ALU: ADD = A+B+Cin, SUB = A+~B+Cin
  always_comb begin
    {alu_cout, alu_f} = '0;
    if (alu_c == ALU_OP_ADD)
      {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
    else if (alu_c == ALU_OP_SUB)
      {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, alu_cin};
  end

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
    int           lat;
    int           k;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (md.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: actual done=1 required no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, md.result_hi, e.hi);
        chk({e.name, "_lo"}, md.result_lo, e.lo);
        chk({e.name, "_dbz"}, {{(N-1){1'b0}}, md.div_by_zero}, {{(N-1){1'b0}}, e.dbz});
        chk_int({e.name, "_latency"}, cyc - e.k, e.lat);
      end
    end
  end

  // Issue one request; operands are scrambled after capture to prove they are latched
  task automatic issue(input string nm, input logic op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] ehi,
                       input logic [N-1:0] elo, input logic edbz, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    md.a     = ~a;
    md.b     = ~b;
    md.op    = ~op;
    if (push) begin
      e.hi   = ehi;
      e.lo   = elo;
      e.dbz  = edbz;
      e.lat  = (op == MD_OP_DIV && b == '0) ? 0 : N;
      e.k    = cyc;
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((md.busy !== 1'b0 || sb.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 200) begin
      n_bad++;
      $display("FAIL %s_timeout: actual busy=%b pending=%0d required idle", nm, md.busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_idle_port(input string nm);
    chk({nm, "_busy"}, {{(N-1){1'b0}}, md.busy}, '0);
    chk({nm, "_done"}, {{(N-1){1'b0}}, md.done}, '0);
    chk({nm, "_alu_c"}, {{(N-3){1'b0}}, alu_c}, {{(N-3){1'b0}}, ALU_OP_ADD});
    chk({nm, "_alu_cin"}, {{(N-1){1'b0}}, alu_cin}, '0);
    chk({nm, "_alu_a"}, alu_a, '0);
    chk({nm, "_alu_b"}, alu_b, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    md.start = 1'b0;
    md.op    = MD_OP_MUL;
    md.a     = '0;
    md.b     = '0;
    #12;
    chk_idle_port("reset");
    chk("reset_hi", md.result_hi, '0);
    chk("reset_lo", md.result_lo, '0);
    chk("reset_dbz", {{(N-1){1'b0}}, md.div_by_zero}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply: first RUN cycle adds HI=0 + multiplicand
    issue("mul_7x6", MD_OP_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1);
    @(negedge clk);
    chk("mul_run_busy", {{(N-1){1'b0}}, md.busy}, 32'd1);
    chk("mul_run_alu_c", {{(N-3){1'b0}}, alu_c}, {{(N-3){1'b0}}, ALU_OP_ADD});
    chk("mul_run_alu_b", alu_b, 32'd7);
    wait_idle("mul_7x6");
    chk_idle_port("after_mul");

    issue("mul_max", MD_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    wait_idle("mul_max");
    issue("mul_shift", MD_OP_MUL, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b1);
    wait_idle("mul_shift");

    // Divide: SUB with carry-in 1 against the divisor
    issue("div_100_7", MD_OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    @(negedge clk);
    chk("div_run_alu_c", {{(N-3){1'b0}}, alu_c}, {{(N-3){1'b0}}, ALU_OP_SUB});
    chk("div_run_alu_cin", {{(N-1){1'b0}}, alu_cin}, 32'd1);
    chk("div_run_alu_b", alu_b, 32'd7);
    wait_idle("div_100_7");

    issue("div_hibit", MD_OP_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    wait_idle("div_hibit");
    issue("div_by_1", MD_OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_idle("div_by_1");
    issue("div_eq", MD_OP_DIV, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1, 1'b0, 1'b1);
    wait_idle("div_eq");

    // Divide by zero: done in the first cycle, results and flag held afterwards
    issue("div_zero", MD_OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle("div_zero");
    repeat (3) @(negedge clk);
    chk("dz_hold_hi", md.result_hi, 32'd5);
    chk("dz_hold_lo", md.result_lo, 32'hFFFF_FFFF);
    chk("dz_hold_flag", {{(N-1){1'b0}}, md.div_by_zero}, 32'd1);
    chk_idle_port("dz_idle");

    issue("mul_clr_dz", MD_OP_MUL, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
    wait_idle("mul_clr_dz");

    // start during RUN is ignored
    issue("mul_ignore", MD_OP_MUL, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    md.start = 1'b1;
    md.op    = MD_OP_DIV;
    md.a     = 32'd1;
    md.b     = 32'd0;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    wait_idle("mul_ignore");
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-RUN: immediate idle, no done afterwards
    issue("rst_mid", MD_OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_idle_port("rst_mid");
    chk("rst_mid_hi", md.result_hi, '0);
    chk("rst_mid_lo", md.result_lo, '0);
    chk("rst_mid_dbz", {{(N-1){1'b0}}, md.div_by_zero}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue("mul_after_rst", MD_OP_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1);
    wait_idle("mul_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
